bus_arbiter_rr: RTL

//  Round-robin bus arbiter: the initiating end of the grant/ack handshake served by the bus slave.

---
 rtl/bus_arbiter_rr_if.sv | 26 ++
 rtl/bus_arbiter_rr.sv | 107 ++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr_if.sv
// Grant/ack handshake bundle between the round-robin arbiter and the bus slave.
// The master modport is the arbiter side; the slave modport is the side that answers grants.
interface bus_arbiter_rr_if #(
  parameter int unsigned N_MASTERS = 4
) ();
  localparam int unsigned IDX_W = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0] bus_req;
  logic                 bus_ack;
  logic [N_MASTERS-1:0] bus_grant;
  logic [IDX_W-1:0]     grant_idx;

  modport master (
    input  bus_req,
    input  bus_ack,
    output bus_grant,
    output grant_idx
  );

  modport slave (
    output bus_req,
    output bus_ack,
    input  bus_grant,
    input  grant_idx
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with grant timeout, post-timeout recovery window and
// saturating completion/timeout counters. All outputs are registered.
module bus_arbiter_rr #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT        = 8,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_rr_if.master bus,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int unsigned IDX_W    = $clog2(N_MASTERS);
  localparam int unsigned WAIT_MAX = (TIMEOUT > RECOVER_CYCLES) ? TIMEOUT : RECOVER_CYCLES;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    cand;
  logic                found;

  // First requesting master after the pointer, wrapping around.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_MASTERS);
      if (!found && bus.bus_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.bus_grant <= '0;
      bus.grant_idx <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      done_count    <= '0;
      timeout_count <= '0;
      ptr           <= IDX_W'(N_MASTERS - 1);
      wait_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.bus_grant <= N_MASTERS'(1) << sel;
            bus.grant_idx <= sel;
            ptr           <= sel;
            busy          <= 1'b1;
            wait_cnt      <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus.bus_ack) begin
            bus.bus_grant <= '0;
            busy          <= 1'b0;
            if (done_count != '1) done_count <= done_count + CNT_W'(1);
            state         <= IDLE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            bus.bus_grant <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b1;
            if (timeout_count != '1) timeout_count <= timeout_count + CNT_W'(1);
            wait_cnt      <= '0;
            state         <= RECOVER;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RECOVER: begin
          if (wait_cnt == WAIT_W'(RECOVER_CYCLES - 1)) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          bus.bus_grant <= '0;
          busy          <= 1'b0;
          wait_cnt      <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule
